// File: rtl/i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// i2c_bus_monitor
//
// Passive I2C bus monitor. It watches the raw SCL/SDA wires, conditions them
// (2-flop synchronizer plus a run-length glitch filter), and decodes START,
// repeated START, STOP and 9-bit byte frames. Each bus event becomes one
// 13-bit record pushed into a small circular FIFO. The FIFO is read through
// a valid/ready handshake.
//
// Ports
//   clk            system clock (only clock)
//   rst_n          synchronous, active-low reset
//   scl_i, sda_i   raw bus lines, asynchronous to clk
//   rec_valid_o    FIFO head holds a record
//   rec_ready_i    consumer accepts the head when valid & ready
//   rec_kind_o     0 START, 1 RSTART, 2 BYTE, 3 STOP
//   rec_data_o     byte value (MSB first on the bus), 0 for non-BYTE
//   rec_ack_o      9th-bit SDA level (0 ACK, 1 NACK), 0 for non-BYTE
//   rec_is_addr_o  BYTE is the first byte after START/RSTART
//   rec_op_o       R/W bit (rec_data_o[0]) of an address byte, else 0
//   bus_busy_o     high from START until STOP
//   overflow_o     sticky: a record was dropped because the FIFO was full
//   frame_err_o    sticky: START/STOP arrived with a partial byte collected
// ---------------------------------------------------------------------------
module i2c_bus_monitor #(
   parameter int FIFO_DEPTH    = 8,
   parameter int GLITCH_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       rec_valid_o,
   input  logic       rec_ready_i,
   output logic [1:0] rec_kind_o,
   output logic [7:0] rec_data_o,
   output logic       rec_ack_o,
   output logic       rec_is_addr_o,
   output logic       rec_op_o,
   output logic       bus_busy_o,
   output logic       overflow_o,
   output logic       frame_err_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int FLT_W = $clog2(GLITCH_CYCLES + 1);

   localparam logic [1:0] KIND_START  = 2'd0;
   localparam logic [1:0] KIND_RSTART = 2'd1;
   localparam logic [1:0] KIND_BYTE   = 2'd2;
   localparam logic [1:0] KIND_STOP   = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
      logic       ack;
      logic       is_addr;
      logic       op;
   } rec_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Input conditioning: index 0 is SCL, index 1 is SDA. Both lines share an
   // identical pipeline so that a simultaneous pin change reaches the
   // filtered levels in the same cycle.
   // ------------------------------------------------------------------------
   logic [1:0] line_raw;
   logic [1:0] line_filt;

   assign line_raw = {sda_i, scl_i};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cond
         logic             meta_reg;
         logic             sync_reg;
         logic             filt_reg;
         logic [FLT_W-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               meta_reg <= 1'b1;
               sync_reg <= 1'b1;
               filt_reg <= 1'b1;
               cnt_reg  <= '0;
            end else begin
               meta_reg <= line_raw[gi];
               sync_reg <= meta_reg;
               // Count consecutive samples that disagree with the filtered
               // level; any agreeing sample restarts the run.
               if (sync_reg == filt_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == FLT_W'(GLITCH_CYCLES - 1)) begin
                  filt_reg <= sync_reg;
                  cnt_reg  <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign line_filt[gi] = filt_reg;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Edge detection on the filtered levels
   // ------------------------------------------------------------------------
   logic scl_f;
   logic sda_f;
   logic scl_prev_reg;
   logic sda_prev_reg;
   logic scl_rise;
   logic sda_fall;
   logic sda_rise;
   logic scl_held_high;
   logic start_det;
   logic stop_det;

   assign scl_f = line_filt[0];
   assign sda_f = line_filt[1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_prev_reg <= 1'b1;
         sda_prev_reg <= 1'b1;
      end else begin
         scl_prev_reg <= scl_f;
         sda_prev_reg <= sda_f;
      end
   end

   assign scl_rise      = scl_f & ~scl_prev_reg;
   assign sda_fall      = ~sda_f & sda_prev_reg;
   assign sda_rise      = sda_f & ~sda_prev_reg;
   // SCL must be high both before and after the SDA edge; this also rules
   // out START/STOP when SCL and SDA change in the same cycle.
   assign scl_held_high = scl_f & scl_prev_reg;
   assign start_det     = sda_fall & scl_held_high;
   assign stop_det      = sda_rise & scl_held_high;

   // ------------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------------
   state_t     state_reg;
   logic [3:0] bit_cnt_reg;
   logic [7:0] shift_reg;
   logic       busy_reg;
   logic       frame_err_reg;

   // Push request decoded from the current state and this cycle's strobes.
   // It is written into the FIFO on the same clock edge that advances the
   // FSM, so the record is visible one cycle after the strobe.
   logic push_en;
   rec_t push_rec;

   always_comb begin
      push_en  = 1'b0;
      push_rec = '0;
      if (stop_det) begin
         push_en       = 1'b1;
         push_rec.kind = KIND_STOP;
      end else if (start_det) begin
         push_en       = 1'b1;
         push_rec.kind = (state_reg == ST_IDLE) ? KIND_START : KIND_RSTART;
      end else if (scl_rise && (state_reg != ST_IDLE) && (bit_cnt_reg == 4'd8)) begin
         push_en          = 1'b1;
         push_rec.kind    = KIND_BYTE;
         push_rec.data    = shift_reg;
         push_rec.ack     = sda_f;
         push_rec.is_addr = (state_reg == ST_ADDR);
         push_rec.op      = (state_reg == ST_ADDR) ? shift_reg[0] : 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         bit_cnt_reg   <= 4'd0;
         shift_reg     <= 8'h00;
         busy_reg      <= 1'b0;
         frame_err_reg <= 1'b0;
      end else if (stop_det) begin
         // A partially collected byte is dropped silently but flagged.
         if (bit_cnt_reg != 4'd0) frame_err_reg <= 1'b1;
         state_reg   <= ST_IDLE;
         bit_cnt_reg <= 4'd0;
         busy_reg    <= 1'b0;
      end else if (start_det) begin
         if (bit_cnt_reg != 4'd0) frame_err_reg <= 1'b1;
         state_reg   <= ST_ADDR;
         bit_cnt_reg <= 4'd0;
         busy_reg    <= 1'b1;
      end else if (scl_rise && (state_reg != ST_IDLE)) begin
         if (bit_cnt_reg == 4'd8) begin
            // 9th rise: ACK bit sampled, byte record pushed above.
            bit_cnt_reg <= 4'd0;
            state_reg   <= ST_DATA;
         end else begin
            shift_reg   <= {shift_reg[6:0], sda_f};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
         end
      end
   end

   assign bus_busy_o  = busy_reg;
   assign frame_err_o = frame_err_reg;

   // ------------------------------------------------------------------------
   // Record FIFO
   // ------------------------------------------------------------------------
   rec_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             overflow_reg;
   logic             fifo_full;
   logic             pop;
   logic             push_ok;
   rec_t             head;

   assign fifo_full   = (count_reg == CNT_W'(FIFO_DEPTH));
   assign rec_valid_o = (count_reg != '0);
   assign pop         = rec_valid_o & rec_ready_i;
   // When full, a simultaneous pop frees the slot the push will take.
   assign push_ok     = push_en & (~fifo_full | pop);

   // Storage has no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= push_rec;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         // Power-of-two depth: pointers wrap by natural overflow.
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (push_en && fifo_full && !pop) overflow_reg <= 1'b1;
      end
   end

   assign overflow_o = overflow_reg;

   // Head fields are forced to 0 while empty so the outputs read 0 after
   // reset even though the storage itself is not cleared.
   assign head          = mem[rd_ptr_reg];
   assign rec_kind_o    = rec_valid_o ? head.kind    : 2'd0;
   assign rec_data_o    = rec_valid_o ? head.data    : 8'h00;
   assign rec_ack_o     = rec_valid_o ? head.ack     : 1'b0;
   assign rec_is_addr_o = rec_valid_o ? head.is_addr : 1'b0;
   assign rec_op_o      = rec_valid_o ? head.op      : 1'b0;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_monitor
//
// Drives I2C bus waveforms (with randomized phase lengths, addresses, data
// and ACK bits) into i2c_bus_monitor. A transaction-level model builds the
// list of records each bus action should produce; a consumer process
// collects the records the DUT hands out, and each test compares the two.
// ---------------------------------------------------------------------------
module tb_i2c_bus_monitor;

   localparam int FIFO_DEPTH    = 8;
   localparam int GLITCH_CYCLES = 2;

   localparam logic [1:0] K_START  = 2'd0;
   localparam logic [1:0] K_RSTART = 2'd1;
   localparam logic [1:0] K_BYTE   = 2'd2;
   localparam logic [1:0] K_STOP   = 2'd3;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       scl       = 1'b1;
   logic       sda       = 1'b1;
   logic       rec_ready = 1'b1;
   logic       rec_valid;
   logic [1:0] rec_kind;
   logic [7:0] rec_data;
   logic       rec_ack;
   logic       rec_is_addr;
   logic       rec_op;
   logic       bus_busy;
   logic       overflow;
   logic       frame_err;

   int checks = 0;
   int errors = 0;

   logic [12:0] exp_q[$];
   logic [12:0] got_q[$];

   // Transaction-level model state
   bit in_xfer      = 1'b0;
   bit next_addr    = 1'b0;
   bit hold_mode    = 1'b0;
   bit exp_overflow = 1'b0;
   int held         = 0;
   int half         = 6;

   logic [12:0] head_now;
   logic [17:0] all_out;

   assign head_now = {rec_kind, rec_data, rec_ack, rec_is_addr, rec_op};
   assign all_out  = {rec_valid, rec_kind, rec_data, rec_ack, rec_is_addr,
                      rec_op, bus_busy, overflow, frame_err};

   always #5 clk = ~clk;

   i2c_bus_monitor #(
      .FIFO_DEPTH    (FIFO_DEPTH),
      .GLITCH_CYCLES (GLITCH_CYCLES)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .scl_i         (scl),
      .sda_i         (sda),
      .rec_valid_o   (rec_valid),
      .rec_ready_i   (rec_ready),
      .rec_kind_o    (rec_kind),
      .rec_data_o    (rec_data),
      .rec_ack_o     (rec_ack),
      .rec_is_addr_o (rec_is_addr),
      .rec_op_o      (rec_op),
      .bus_busy_o    (bus_busy),
      .overflow_o    (overflow),
      .frame_err_o   (frame_err)
   );

   // Consumer: records handed over on this cycle's handshake.
   always @(negedge clk) begin
      if (rst_n && rec_valid && rec_ready) begin
         got_q.push_back(head_now);
         $display("[%0t] rec kind=%0d data=%02h ack=%0b is_addr=%0b op=%0b",
                  $time, rec_kind, rec_data, rec_ack, rec_is_addr, rec_op);
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Model
   // ---------------------------------------------------------------------
   function automatic logic [12:0] mk(logic [1:0] k, logic [7:0] d, logic a, logic ia);
      logic [7:0] dd;
      logic       aa;
      dd = (k == K_BYTE) ? d : 8'h00;
      aa = (k == K_BYTE) ? a : 1'b0;
      return {k, dd, aa, ia, ia ? d[0] : 1'b0};
   endfunction

   task automatic expect_rec(logic [12:0] r);
      if (hold_mode) begin
         if (held < FIFO_DEPTH) begin
            exp_q.push_back(r);
            held++;
         end else begin
            exp_overflow = 1'b1;
         end
      end else begin
         exp_q.push_back(r);
      end
   endtask

   // ---------------------------------------------------------------------
   // Bus drivers
   // ---------------------------------------------------------------------
   task automatic wait_cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_half();
      half = $urandom_range(GLITCH_CYCLES + 3, GLITCH_CYCLES + 6);
   endtask

   task automatic bus_bit(logic b);
      sda = b;
      wait_cyc(half);
      scl = 1'b1;
      wait_cyc(half);
      scl = 1'b0;
      wait_cyc(half);
   endtask

   task automatic bus_bits(int n);
      for (int i = 0; i < n; i++) bus_bit(1'($urandom_range(0, 1)));
   endtask

   task automatic bus_start();
      if (!scl) begin
         sda = 1'b1;
         wait_cyc(half);
         scl = 1'b1;
         wait_cyc(half);
      end
      sda = 1'b0;
      wait_cyc(half);
      scl = 1'b0;
      wait_cyc(half);
      expect_rec(mk(in_xfer ? K_RSTART : K_START, 8'h00, 1'b0, 1'b0));
      in_xfer   = 1'b1;
      next_addr = 1'b1;
   endtask

   task automatic bus_byte(logic [7:0] d, logic a);
      for (int i = 7; i >= 0; i--) bus_bit(d[i]);
      bus_bit(a);
      if (in_xfer) expect_rec(mk(K_BYTE, d, a, next_addr));
      next_addr = 1'b0;
   endtask

   task automatic bus_stop();
      sda = 1'b0;
      wait_cyc(half);
      scl = 1'b1;
      wait_cyc(half);
      sda = 1'b1;
      wait_cyc(half);
      expect_rec(mk(K_STOP, 8'h00, 1'b0, 1'b0));
      in_xfer = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      wait_cyc(3);
      checks++;
      if (all_out !== 18'h0) begin
         errors++;
         $display("FAIL reset_outputs got %05h want 00000", all_out);
      end
      rst_n = 1'b1;
      wait_cyc(6);
      checks++;
      if (all_out !== 18'h0) begin
         errors++;
         $display("FAIL idle_after_reset got %05h want 00000", all_out);
      end
   endtask

   task automatic test_rstart_midbyte();
      logic [7:0] d;
      got_q.delete();
      exp_q.delete();
      set_half();
      bus_start();
      bus_byte(8'h44, 1'b0);
      checks++;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL rstart_frame_err_before got %0b want 0", frame_err);
      end
      d = 8'($urandom);
      for (int i = 7; i >= 4; i--) bus_bit(d[i]);
      bus_start();
      checks++;
      if (frame_err !== 1'b1) begin
         errors++;
         $display("FAIL rstart_frame_err_after got %0b want 1", frame_err);
      end
      bus_byte(8'h45, 1'b0);
      bus_stop();
      wait_cyc(20);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rstart_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rstart_rec%0d got %04h want %04h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_write_ack();
      got_q.delete();
      exp_q.delete();
      set_half();
      bus_start();
      checks++;
      if (bus_busy !== 1'b1) begin
         errors++;
         $display("FAIL write_busy_high got %0b want 1", bus_busy);
      end
      bus_byte(8'h44, 1'b0);
      bus_byte(8'h55, 1'b0);
      checks++;
      if (bus_busy !== 1'b1) begin
         errors++;
         $display("FAIL write_busy_mid got %0b want 1", bus_busy);
      end
      bus_stop();
      wait_cyc(20);
      checks++;
      if (bus_busy !== 1'b0) begin
         errors++;
         $display("FAIL write_busy_low got %0b want 0", bus_busy);
      end
      checks++;
      if (overflow !== exp_overflow) begin
         errors++;
         $display("FAIL write_overflow got %0b want %0b", overflow, exp_overflow);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL write_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL write_rec%0d got %04h want %04h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_read_nack();
      got_q.delete();
      exp_q.delete();
      set_half();
      bus_start();
      bus_byte(8'h45, 1'b0);
      bus_byte(8'hA5, 1'b0);
      bus_byte(8'h3C, 1'b1);
      bus_stop();
      wait_cyc(20);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL read_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL read_rec%0d got %04h want %04h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_glitch();
      got_q.delete();
      exp_q.delete();
      set_half();
      // One-cycle SDA dip while SCL is high on an idle bus
      sda = 1'b0;
      wait_cyc(1);
      sda = 1'b1;
      wait_cyc(half);
      checks++;
      if ({bus_busy, rec_valid} !== 2'b00 || got_q.size() != 0) begin
         errors++;
         $display("FAIL glitch_sda got busy=%0b valid=%0b recs=%0d want 0 0 0",
                  bus_busy, rec_valid, got_q.size());
      end
      bus_start();
      bus_byte({7'($urandom), 1'b0}, 1'b0);
      // One-cycle SCL pulse during the low phase
      scl = 1'b1;
      wait_cyc(1);
      scl = 1'b0;
      wait_cyc(half);
      bus_byte(8'($urandom), 1'b0);
      bus_stop();
      wait_cyc(20);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL glitch_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL glitch_rec%0d got %04h want %04h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int nbytes;
      got_q.delete();
      exp_q.delete();
      for (int t = 0; t < 4; t++) begin
         set_half();
         bus_start();
         bus_byte(8'($urandom), 1'($urandom_range(0, 1)));
         nbytes = $urandom_range(1, 3);
         for (int b = 0; b < nbytes; b++) bus_byte(8'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            bus_start();
            bus_byte(8'($urandom), 1'($urandom_range(0, 1)));
            bus_byte(8'($urandom), 1'($urandom_range(0, 1)));
         end
         bus_stop();
      end
      wait_cyc(20);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_rec%0d got %04h want %04h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_overflow();
      logic [12:0] head_early;
      got_q.delete();
      exp_q.delete();
      set_half();
      rec_ready    = 1'b0;
      hold_mode    = 1'b1;
      held         = 0;
      exp_overflow = 1'b0;
      // START + address + 7 data bytes + STOP = 10 records
      bus_start();
      bus_byte(8'($urandom), 1'b0);
      bus_byte(8'($urandom), 1'b0);
      head_early = head_now;
      for (int b = 0; b < 6; b++) bus_byte(8'($urandom), 1'($urandom_range(0, 1)));
      bus_stop();
      wait_cyc(20);
      checks++;
      if (overflow !== exp_overflow) begin
         errors++;
         $display("FAIL ovf_flag got %0b want %0b", overflow, exp_overflow);
      end
      checks++;
      if (rec_valid !== 1'b1 || head_now !== exp_q[0]) begin
         errors++;
         $display("FAIL ovf_head got valid=%0b %04h want 1 %04h", rec_valid, head_now, exp_q[0]);
      end
      checks++;
      if (head_early !== exp_q[0]) begin
         errors++;
         $display("FAIL ovf_head_stable got %04h want %04h", head_early, exp_q[0]);
      end
      rec_ready = 1'b1;
      hold_mode = 1'b0;
      wait_cyc(FIFO_DEPTH + 10);
      checks++;
      if (rec_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_drained_valid got %0b want 0", rec_valid);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL ovf_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL ovf_rec%0d got %04h want %04h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_midbyte();
      got_q.delete();
      exp_q.delete();
      set_half();
      bus_start();
      bus_byte({7'($urandom), 1'b1}, 1'b0);
      bus_bits(5);
      rst_n = 1'b0;
      wait_cyc(1);
      checks++;
      if (all_out !== 18'h0) begin
         errors++;
         $display("FAIL rst_mid_outputs got %05h want 00000", all_out);
      end
      rst_n        = 1'b1;
      in_xfer      = 1'b0;
      next_addr    = 1'b0;
      exp_overflow = 1'b0;
      got_q.delete();
      exp_q.delete();
      bus_bits(4);
      checks++;
      if (rec_valid !== 1'b0 || got_q.size() != 0) begin
         errors++;
         $display("FAIL rst_mid_trailing got valid=%0b recs=%0d want 0 0", rec_valid, got_q.size());
      end
      bus_start();
      checks++;
      if ({bus_busy, frame_err} !== 2'b10) begin
         errors++;
         $display("FAIL rst_mid_restart got busy=%0b ferr=%0b want 1 0", bus_busy, frame_err);
      end
      bus_stop();
      wait_cyc(20);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rst_mid_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rst_mid_rec%0d got %04h want %04h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rstart_midbyte();
      test_write_ack();
      test_read_nack();
      test_glitch();
      test_back_to_back();
      test_overflow();
      test_reset_midbyte();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Passive, synthesizable I2C bus monitor that watches SCL/SDA, decodes START, repeated START, STOP and 9-bit byte frames, and emits one record per bus event through a valid/ready FIFO. It sits directly downstream of the I2C bus wires driven by the I2CMB DUT and the slave BFM. It feeds the I2C monitor/predictor, which turns records into transactions typed by the write/read operation enum (write = 0, read = 1).

## Interface
- FIFO_DEPTH, 8: record FIFO entries; power of two, minimum 2.
- GLITCH_CYCLES, 2: consecutive equal synchronized samples required before a filtered level changes; minimum 1.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous and active-low.
- scl_i  in  1  raw bus SCL, asynchronous to clk.
- sda_i  in  1  raw bus SDA, asynchronous to clk.
- rec_valid_o  out  1  FIFO head holds a record.
- rec_ready_i  in  1  consumer accepts the head record when valid and ready are both high.
- rec_kind_o  out  2  0 = START, 1 = RSTART, 2 = BYTE, 3 = STOP.
- rec_data_o  out  8  byte value, MSB first on the bus; 0 for non-BYTE records.
- rec_ack_o  out  1  9th-bit SDA level: 0 = ACK, 1 = NACK; 0 for non-BYTE records.
- rec_is_addr_o  out  1  BYTE is the first byte after START/RSTART.
- rec_op_o  out  1  rec_data_o[0] when rec_is_addr_o is 1, otherwise 0.
- bus_busy_o  out  1  high from START until STOP.
- overflow_o  out  1  sticky; a record was dropped because the FIFO was full.
- frame_err_o  out  1  sticky; START or STOP arrived with 1–8 bits of a byte collected.

## Operation
- **Input conditioning:** a 2-flop synchronizer per line feeds a filter. The filtered level changes only after GLITCH_CYCLES consecutive samples differ from it. Filtered SCL and SDA reset to 1.
- **Edge detection:** one-cycle strobes from the filtered levels: scl_rise, sda_fall, sda_rise.
- **START:** sda_fall while filtered SCL is 1 in both the previous and current cycle.
- **STOP:** sda_rise under the same condition.
- **Simultaneous edges:** if filtered SCL and SDA change in the same cycle, no START/STOP is detected. Only the SCL edge is processed, and it samples the new SDA value.
- **FSM states:** IDLE, ADDR, DATA.
  - IDLE: SCL edges are ignored. START pushes START and goes to ADDR, bit_cnt = 0.
  - ADDR/DATA: on each scl_rise, shift SDA into the byte (bits 0–7) and increment bit_cnt. The 9th rise captures the ACK, pushes BYTE and clears bit_cnt.
  - The BYTE push from ADDR sets is_addr = 1 and moves to DATA. Pushes from DATA have is_addr = 0 and stay in DATA.
  - START in ADDR/DATA pushes RSTART and goes to ADDR.
  - STOP in any state pushes STOP and goes to IDLE.
  - START or STOP with bit_cnt in 1..8 discards the partial byte (no record) and sets frame_err_o.
  - STOP in IDLE is still pushed as a STOP record.
- **Address decode:** the read/write bit is the 8th bit sampled (rec_data_o[0]).
- **bus_busy_o:** set on START, cleared on STOP.
- **Record FIFO:** 13-bit records, circular, pointers wrap modulo FIFO_DEPTH; rec_valid_o = not empty.
  - A push when full and no pop drops the new record and sets overflow_o.
  - A push and pop in the same cycle while full is accepted; the count is unchanged.
  - A push and pop in the same cycle while empty: the record becomes visible the next cycle; there is no bypass.

## Timing
- Reset (rst_n = 0 at a clk edge):
  - state IDLE, bit_cnt 0, FIFO empty, filter counters 0, filtered levels 1.
  - all outputs 0: rec_valid_o, rec_kind_o, rec_data_o, rec_ack_o, rec_is_addr_o, rec_op_o, bus_busy_o, overflow_o, frame_err_o.
- Reset mid-transfer discards all state. Bus activity is ignored until the next START.
- Pin-to-filtered latency: 2 + GLITCH_CYCLES clk cycles for a stable change.
- Pulses shorter than GLITCH_CYCLES synchronized samples are suppressed.
- Detection to rec_valid_o: the edge strobe occurs in cycle E; the FSM pushes at the end of E; the record is on the outputs and rec_valid_o is high in E+1 (if the FIFO was empty).
- Record outputs are driven from the FIFO head and remain stable while rec_valid_o = 1 and rec_ready_i = 0.
- Bus requirement: SCL high and low phases of at least GLITCH_CYCLES + 2 clk cycles.

## Test plan
- **Write, ACKed:** START, addr 0x22 + W, ACK, data 0x55, ACK, STOP, rec_ready_i = 1 → four records:
  - START
  - BYTE 0x44, is_addr = 1, op = 0, ack = 0
  - BYTE 0x55, is_addr = 0, ack = 0
  - STOP
  - bus_busy_o high between START and STOP.
- **Read ending in NACK:** addr 0x22 + R, data 0xA5 then 0x3C NACK, STOP → BYTE 0x45 (op = 1), BYTE 0xA5 ack = 0, BYTE 0x3C ack = 1, STOP.
- **Repeated START mid-byte:** after 4 data bits, RSTART, addr 0x22 + R → no partial BYTE, RSTART record, frame_err_o = 1, next BYTE 0x45 is_addr = 1.
- **Overflow:** rec_ready_i = 0, generate 10 records with FIFO_DEPTH = 8 → exactly 8 records held (first 8 in order), overflow_o = 1. Then rec_ready_i = 1 drains those 8 and rec_valid_o drops.
- **Glitch suppression:** with GLITCH_CYCLES = 2, a 1-cycle SDA low pulse while SCL is high, and a 1-cycle SCL pulse → no START and no extra bit; records unchanged.
- **Reset mid-byte:** rst_n low for 1 cycle after 5 bits → all outputs 0. Trailing bits produce no record; the next START yields a START record.
